// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 job scheduler.
package hash160_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int          SHA256_BLOCK_BYTES = 64;
  localparam logic [7:0]  PAD_BYTE           = 8'h80;
  localparam int          LEN_FIELD_BYTES    = 8;
  localparam int          RIPEMD160_DIGEST_W = 160;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    gnt_idx
);

  int   idx;
  logic found;

  // Walk the NUM_REQ positions after last_grant, wrapping, and take the first hit.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found               = 1'b1;
        gnt_idx             = ID_W'(idx);
        gnt_oh[ID_W'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash160_job_scheduler.sv
// Shares one Hash160 core among NUM_REQ byte-streaming requesters:
// arbitrate, collect message, pad to one SHA-256 block, run core, respond.
module hash160_job_scheduler
  import hash160_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MAX_LEN = 55,
  parameter int TIMEOUT = 2047
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [8*NUM_REQ-1:0]          req_byte,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [8*SHA256_BLOCK_BYTES-1:0] core_m,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [RIPEMD160_DIGEST_W-1:0] core_digest,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [RIPEMD160_DIGEST_W-1:0] rsp_digest,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int                CNT_W    = $clog2(SHA256_BLOCK_BYTES);
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(SHA256_BLOCK_BYTES - 1);

  // Byte i of the block lives in buf[63-i] so the packed vector is big-endian.
  typedef logic [SHA256_BLOCK_BYTES-1:0][7:0] blk_t;

  state_e                        state_q, state_d;
  logic [ID_W-1:0]               grant_q, grant_d, last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]            grant_oh_q, grant_oh_d;
  blk_t                          buf_q, buf_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, len_q, len_d;
  logic                          ovf_q, ovf_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic [RIPEMD160_DIGEST_W-1:0] dig_q, dig_d;
  logic                          err_q, err_d;

  logic [NUM_REQ-1:0][7:0]       req_bytes;
  logic [NUM_REQ-1:0]            arb_oh;
  logic [ID_W-1:0]               arb_idx;
  logic                          acc;

  assign req_bytes = req_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_oh     (arb_oh),
    .gnt_idx    (arb_idx)
  );

  // Job sequencing, buffer fill/pad, timeout and response outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    dig_d        = dig_q;
    err_d        = err_q;
    req_ready    = '0;
    core_m       = '0;
    core_start   = 1'b0;
    rsp_valid    = 1'b0;
    rsp_id       = '0;
    rsp_digest   = '0;
    rsp_err      = 1'b0;
    busy         = (state_q != S_IDLE);
    acc          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        req_ready = grant_oh_q;
        acc       = |(req_valid & grant_oh_q);
        if (acc) begin
          if (ovf_q || cnt_q == CNT_W'(MAX_LEN)) begin
            // Too long for one block: drop bytes, report error without the core.
            ovf_d = 1'b1;
            if (req_last[grant_q]) begin
              err_d   = 1'b1;
              dig_d   = '0;
              state_d = S_RESP;
            end
          end else begin
            buf_d[LAST_IDX - cnt_q] = req_bytes[grant_q];
            cnt_d = cnt_q + 1'b1;
            if (req_last[grant_q]) begin
              len_d   = cnt_q + 1'b1;
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < SHA256_BLOCK_BYTES - LEN_FIELD_BYTES; i++) begin
          if (i == int'(len_q))     buf_d[SHA256_BLOCK_BYTES-1-i] = PAD_BYTE;
          else if (i > int'(len_q)) buf_d[SHA256_BLOCK_BYTES-1-i] = 8'h00;
        end
        buf_d[LEN_FIELD_BYTES-1:0] = 64'({len_q, 3'b000});
        state_d = S_START;
      end
      S_START: begin
        core_m     = buf_q;
        core_start = 1'b1;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        core_m = buf_q;
        // A completion in the final timeout cycle still counts as success.
        if (core_done) begin
          dig_d   = core_digest;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          dig_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = grant_q;
        rsp_digest = dig_q;
        rsp_err    = err_q;
        if (rsp_ready) begin
          last_grant_d = grant_q;
          buf_d        = '0;
          cnt_d        = '0;
          len_d        = '0;
          ovf_d        = 1'b0;
          tmo_d        = '0;
          dig_d        = '0;
          err_d        = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      buf_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= '0;
      dig_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      dig_q        <= dig_d;
      err_q        <= err_d;
    end
  end

endmodule
